// File: rtl/jedro_1_decoder_if.sv
// Decode-stage bus: fetch-side request, register-file read port and the registered ALU-side result.
// The slave modport is the decoder; the master modport is whatever surrounds it.
interface jedro_1_decoder_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   instr_i;
  logic [DATA_WIDTH-1:0]   pc_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [4:0]              rf_addr_a_o;
  logic [4:0]              rf_addr_b_o;
  logic [DATA_WIDTH-1:0]   rf_data_a_i;
  logic [DATA_WIDTH-1:0]   rf_data_b_i;
  logic                    flush_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [ALU_OP_WIDTH-1:0] alu_op_sel_o;
  logic [DATA_WIDTH-1:0]   opa_o;
  logic [DATA_WIDTH-1:0]   opb_o;
  logic [4:0]              rd_addr_o;
  logic                    rd_we_o;
  logic                    illegal_instr_o;

  modport master (
    output instr_i, pc_i, in_valid_i, rf_data_a_i, rf_data_b_i, flush_i, out_ready_i,
    input  in_ready_o, rf_addr_a_o, rf_addr_b_o, out_valid_o, alu_op_sel_o, opa_o, opb_o,
           rd_addr_o, rd_we_o, illegal_instr_o
  );

  modport slave (
    input  instr_i, pc_i, in_valid_i, rf_data_a_i, rf_data_b_i, flush_i, out_ready_i,
    output in_ready_o, rf_addr_a_o, rf_addr_b_o, out_valid_o, alu_op_sel_o, opa_o, opb_o,
           rd_addr_o, rd_we_o, illegal_instr_o
  );
endinterface

// File: rtl/jedro_1_decoder.sv
// RV32I decode stage for OP, OP-IMM, LUI and AUIPC with a single-entry output register.
// Everything else is reported as illegal with a zeroed ADD and no register write.
module jedro_1_decoder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input logic               clk_i,
  input logic               rstn_i,
  jedro_1_decoder_if.slave  bus
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;

  logic                    legal;
  logic [ALU_OP_WIDTH-1:0] alu_op_d;
  logic [DATA_WIDTH-1:0]   opa_d;
  logic [DATA_WIDTH-1:0]   opb_d;
  logic                    accept;

  assign opcode = bus.instr_i[6:0];
  assign rd     = bus.instr_i[11:7];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];

  assign imm_i = {{(DATA_WIDTH-12){bus.instr_i[31]}}, bus.instr_i[31:20]};
  assign imm_u = {bus.instr_i[DATA_WIDTH-1:12], 12'b0};

  assign bus.rf_addr_a_o = bus.instr_i[19:15];
  assign bus.rf_addr_b_o = bus.instr_i[24:20];

  // Flush blocks acceptance so a flushed cycle can never load a new instruction.
  assign bus.in_ready_o = !bus.flush_i && (!bus.out_valid_o || bus.out_ready_i);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    legal    = 1'b0;
    alu_op_d = '0;
    opa_d    = '0;
    opb_d    = '0;
    case (opcode)
      OpcOp: begin
        legal    = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        alu_op_d = {bus.instr_i[30], funct3};
        opa_d    = bus.rf_data_a_i;
        opb_d    = bus.rf_data_b_i;
      end
      OpcOpImm: begin
        unique case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        // Only shifts carry the SRA select in bit 30; elsewhere it is immediate data.
        alu_op_d = {(funct3 == 3'b101) && bus.instr_i[30], funct3};
        opa_d    = bus.rf_data_a_i;
        opb_d    = imm_i;
      end
      OpcLui: begin
        legal = 1'b1;
        opb_d = imm_u;
      end
      OpcAuipc: begin
        legal = 1'b1;
        opa_d = bus.pc_i;
        opb_d = imm_u;
      end
      default: ;
    endcase
    if (!legal) begin
      alu_op_d = '0;
      opa_d    = '0;
      opb_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.out_valid_o     <= 1'b0;
      bus.alu_op_sel_o    <= '0;
      bus.opa_o           <= '0;
      bus.opb_o           <= '0;
      bus.rd_addr_o       <= '0;
      bus.rd_we_o         <= 1'b0;
      bus.illegal_instr_o <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        bus.out_valid_o <= 1'b0;
      end else if (accept) begin
        bus.out_valid_o <= 1'b1;
      end else if (bus.out_ready_i) begin
        bus.out_valid_o <= 1'b0;
      end
      if (accept) begin
        bus.alu_op_sel_o    <= alu_op_d;
        bus.opa_o           <= opa_d;
        bus.opb_o           <= opb_d;
        bus.rd_addr_o       <= rd;
        bus.rd_we_o         <= legal && (rd != 5'd0);
        bus.illegal_instr_o <= !legal;
      end
    end
  end

endmodule
